// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule definitions.
//   - key_len encodings and the controller state type
//   - Nk / Nr / total-word lookups for each key length
//   - GF(2^8) xtime and the RotWord byte rotation
//   - storage sizing: 4*(max_nk+7) words per schedule
package aes_pkg;

  typedef enum logic [1:0] {
    KL_AES128  = 2'b00,
    KL_AES192  = 2'b01,
    KL_AES256  = 2'b10,
    KL_ILLEGAL = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } ks_state_e;

  localparam int AES_MAX_NK = 8;

  // Words needed to hold every round key for the longest supported key.
  function automatic int key_words(input int max_nk);
    return 4 * (max_nk + 7);
  endfunction

  localparam int AES_KEY_WORDS = key_words(AES_MAX_NK);

  // Key length in 32-bit words; 0 marks the illegal encoding.
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    logic [3:0] nk;
    case (kl)
      KL_AES128: nk = 4'd4;
      KL_AES192: nk = 4'd6;
      KL_AES256: nk = 4'd8;
      default:   nk = 4'd0;
    endcase
    return nk;
  endfunction

  // Number of cipher rounds for each key length.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    logic [3:0] nr;
    case (kl)
      KL_AES128: nr = 4'd10;
      KL_AES192: nr = 4'd12;
      KL_AES256: nr = 4'd14;
      default:   nr = 4'd0;
    endcase
    return nr;
  endfunction

  // Total schedule words: 4*(Nr+1) -> 44 / 52 / 60.
  function automatic logic [5:0] total_of(input logic [3:0] nr);
    return {nr, 2'b00} + 6'd4;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Cyclic left rotation by one byte: [a0,a1,a2,a3] -> [a1,a2,a3,a0].
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_schedule_if.sv
// key_schedule_if: key-load / round-key read bundle.
//   master (key loader / round datapath) drives start, key, key_len, rk_idx.
//   slave  (key_schedule) drives ready, keys_valid, err, nr, rk.
//   key is big-endian with word 0 in bits [0:31]; rk likewise.
interface key_schedule_if;
  logic         start;
  logic [0:255] key;
  logic [1:0]   key_len;
  logic         ready;
  logic         keys_valid;
  logic         err;
  logic [3:0]   nr;
  logic [3:0]   rk_idx;
  logic [0:127] rk;

  modport master (
    output start, key, key_len, rk_idx,
    input  ready, keys_valid, err, nr, rk
  );

  modport slave (
    input  start, key, key_len, rk_idx,
    output ready, keys_valid, err, nr, rk
  );
endinterface

// File: rtl/key_schedule_subword.sv
// key_schedule_subword: AES SubWord, four parallel S-boxes on a 32-bit word.
//   word_in  : word to substitute
//   word_out : byte-wise S-box of word_in
// The S-box is computed as the GF(2^8) inverse (x^254) followed by the AES
// affine transform, so no lookup table has to be maintained.
module key_schedule_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    // Addition chain for x^254 (= x^-1, with 0 mapping to 0).
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign word_out[8*gi +: 8] = sbox(word_in[8*gi +: 8]);
  end

endmodule

// File: rtl/key_schedule.sv
// key_schedule: iterative AES-128/192/256 key expansion, one word per clock.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : key_schedule_if.slave
//     start/key/key_len : request expansion (taken when ready=1)
//     ready             : IDLE or DONE, a start can be taken
//     keys_valid        : full schedule for the last accepted key is stored
//     err               : one-cycle pulse after a rejected start
//     nr                : round count of the current schedule (0 after reset)
//     rk_idx/rk         : combinational round-key read, zero past nr
module key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_NK = AES_MAX_NK
) (
  input  logic          clk,
  input  logic          reset,
  key_schedule_if.slave bus
);

  localparam int WORDS = key_words(MAX_NK);
  localparam int IDX_W = $clog2(WORDS);

  ks_state_e        state_q, state_d;
  logic [3:0]       nk_q, nk_d;
  logic [3:0]       nr_q, nr_d;
  logic [IDX_W-1:0] total_q, total_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [2:0]       j_q, j_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             keys_valid_q, keys_valid_d;
  logic             err_q, err_d;

  logic [31:0]      w_q  [WORDS];
  logic [31:0]      w_d  [WORDS];
  logic             w_we [WORDS];

  logic             ready;
  logic             accept;
  logic             illegal;
  logic             load;
  logic [3:0]       nk_req;
  logic [3:0]       nr_req;

  // ---------------------------------------------------------------
  // Start handling
  // ---------------------------------------------------------------
  assign ready   = (state_q != ST_EXPAND);
  assign nk_req  = nk_of(bus.key_len);
  assign nr_req  = nr_of(bus.key_len);
  assign illegal = (bus.key_len == KL_ILLEGAL) || (nk_req > 4'(MAX_NK));
  assign accept  = bus.start && ready;
  assign load    = accept && !illegal;

  // ---------------------------------------------------------------
  // Expansion datapath: w[i] = w[i-Nk] ^ t
  // ---------------------------------------------------------------
  logic [31:0] prev_word;
  logic [31:0] back_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp_word;
  logic [31:0] new_word;
  logic        last_j;
  logic        last_word;

  assign prev_word = w_q[i_q - IDX_W'(1)];
  assign back_word = w_q[i_q - IDX_W'(nk_q)];

  // Single SubWord path: rotated input at the start of each Nk group,
  // plain input for the AES-256 mid-group substitution.
  assign sub_in = (j_q == 3'd0) ? rot_word(prev_word) : prev_word;

  key_schedule_subword u_sub_word (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    temp_word = prev_word;
    if (j_q == 3'd0) begin
      temp_word = sub_out ^ {rcon_q, 24'h000000};
    end else if (nk_q == 4'd8 && j_q == 3'd4) begin
      temp_word = sub_out;
    end
  end

  assign new_word  = back_word ^ temp_word;
  // j counts position within the current Nk group, replacing i mod Nk.
  assign last_j    = (j_q == 3'(nk_q - 4'd1));
  assign last_word = (i_q == total_q - IDX_W'(1));

  // ---------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    nk_d         = nk_q;
    nr_d         = nr_q;
    total_d      = total_q;
    i_d          = i_q;
    j_d          = j_q;
    rcon_d       = rcon_q;
    keys_valid_d = keys_valid_q;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (illegal) begin
            // Rejected request leaves the held schedule untouched.
            err_d = 1'b1;
          end else begin
            state_d      = ST_EXPAND;
            nk_d         = nk_req;
            nr_d         = nr_req;
            total_d      = IDX_W'(total_of(nr_req));
            i_d          = IDX_W'(nk_req);
            j_d          = 3'd0;
            rcon_d       = 8'h01;
            keys_valid_d = 1'b0;
          end
        end
      end
      ST_EXPAND: begin
        i_d = i_q + IDX_W'(1);
        j_d = last_j ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (last_word) begin
          state_d      = ST_DONE;
          keys_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      nk_q         <= 4'd0;
      nr_q         <= 4'd0;
      total_q      <= '0;
      i_q          <= '0;
      j_q          <= 3'd0;
      rcon_q       <= 8'h01;
      keys_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      nk_q         <= nk_d;
      nr_q         <= nr_d;
      total_q      <= total_d;
      i_q          <= i_d;
      j_q          <= j_d;
      rcon_q       <= rcon_d;
      keys_valid_q <= keys_valid_d;
      err_q        <= err_d;
    end
  end

  // ---------------------------------------------------------------
  // Word storage: key words on load, one expanded word per EXPAND cycle.
  // Not reset; reset only abandons whatever partial schedule is held.
  // ---------------------------------------------------------------
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    if (gi < MAX_NK) begin : g_key
      logic key_we;
      assign key_we      = load && (4'(gi) < nk_req);
      assign w_we[gi]    = key_we ||
                           (state_q == ST_EXPAND && i_q == IDX_W'(gi));
      assign w_d[gi]     = key_we ? bus.key[32*gi +: 32] : new_word;
    end else begin : g_exp
      assign w_we[gi]    = (state_q == ST_EXPAND) && (i_q == IDX_W'(gi));
      assign w_d[gi]     = new_word;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < WORDS; k++) begin
      if (w_we[k]) begin
        w_q[k] <= w_d[k];
      end
    end
  end

  // ---------------------------------------------------------------
  // Round-key read port
  // ---------------------------------------------------------------
  logic             rk_oob;
  logic [IDX_W-1:0] rd_base;

  assign rk_oob  = (bus.rk_idx > nr_q);
  // Clamp the base so an out-of-range index never addresses past storage.
  assign rd_base = rk_oob ? '0 : IDX_W'({bus.rk_idx, 2'b00});

  assign bus.rk = rk_oob ? '0 :
                  {w_q[rd_base], w_q[rd_base + IDX_W'(1)],
                   w_q[rd_base + IDX_W'(2)], w_q[rd_base + IDX_W'(3)]};

  assign bus.ready      = ready;
  assign bus.keys_valid = keys_valid_q;
  assign bus.err        = err_q;
  assign bus.nr         = nr_q;

endmodule

// File: tb/tb_key_schedule.sv
// tb_key_schedule: directed test of key_schedule against a FIPS-197 style
// reference model (modulo-indexed expansion, S-box built from brute-force
// field inverses) plus literal round keys from the AES test vectors.
module tb_key_schedule;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_schedule_if bus();

  key_schedule #(.MAX_NK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]   sbox_t  [256];
  logic [127:0] cand_rk [16];
  logic [127:0] exp_rk  [16];

  // Timing model state
  bit         m_live = 1'b0;
  int         m_busy;
  logic       m_kv;
  logic       m_err;
  logic [3:0] m_nr;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KNEW = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KJNK = 256'hdeadbeef_01234567_89abcdef_fedcba98_76543210_0badf00d_cafef00d_13579bdf;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Carry-less product reduced by the AES polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int n = 0; n < 8; n++) if (b[n]) p = p ^ (16'(a) << n);
    for (int n = 14; n >= 8; n--) if (p[n]) p = p ^ (16'h011B << (n - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Reference expansion straight from the FIPS-197 pseudo-code.
  task automatic build_schedule(input logic [255:0] k, input int nk);
    logic [31:0] ww [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr, total;
    nr = nk + 6;
    total = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) ww[i] = k[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = ww[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
        t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_w(t);
      end
      ww[i] = ww[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) cand_rk[r] = {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
      else         cand_rk[r] = '0;
    end
  endtask

  function automatic int kl_nk(input logic [1:0] kl);
    return 4 + 2 * int'(kl);
  endfunction

  // Cycle-level behaviour: accepted start makes the block busy for
  // total-Nk cycles, after which the new schedule is visible.
  always @(posedge clk) begin
    if (reset) begin
      m_live <= 1'b1;
      m_busy <= 0;
      m_kv   <= 1'b0;
      m_err  <= 1'b0;
      m_nr   <= 4'd0;
    end else begin
      m_err <= 1'b0;
      if (m_busy != 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) m_kv <= 1'b1;
      end else if (bus.start) begin
        if (bus.key_len == 2'b11) begin
          m_err <= 1'b1;
        end else begin
          m_busy <= 4 * (kl_nk(bus.key_len) + 7) - kl_nk(bus.key_len);
          m_kv   <= 1'b0;
          m_nr   <= 4'(kl_nk(bus.key_len) + 6);
          for (int r = 0; r < 16; r++) exp_rk[r] <= cand_rk[r];
        end
      end
    end
  end

  // Compare process: every cycle once reset has been seen.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk_int("cyc_ready", int'(bus.ready), int'(m_busy == 0));
        chk_int("cyc_keys_valid", int'(bus.keys_valid), int'(m_kv));
        chk_int("cyc_err", int'(bus.err), int'(m_err));
        chk_int("cyc_nr", int'(bus.nr), int'(m_nr));
        if (m_kv)
          chk("cyc_rk", bus.rk, (bus.rk_idx > m_nr) ? 128'h0 : exp_rk[bus.rk_idx]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_key(input logic [255:0] k, input logic [1:0] kl);
    if (kl != 2'b11) build_schedule(k, kl_nk(kl));
    bus.key     = k;
    bus.key_len = kl;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_kv(output int n);
    n = 0;
    while (!bus.keys_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic read_rk(input string name, input logic [3:0] idx, input logic [127:0] want);
    bus.rk_idx = idx;
    #1;
    chk(name, bus.rk, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.key     = '0;
    bus.key_len = 2'b00;
    bus.rk_idx  = 4'd0;
    build_sbox();
    chk("model_sbox_00", 128'(sbox_t[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    repeat (3) tick();
    chk_int("reset_ready", int'(bus.ready), 1);
    chk_int("reset_keys_valid", int'(bus.keys_valid), 0);
    chk_int("reset_nr", int'(bus.nr), 0);
    reset = 1'b0;
    tick();

    $display("txn aes128 expand");
    start_key(K128, 2'b00);
    chk("model_aes128_rk10", cand_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_kv(n);
    chk_int("aes128_latency", n, 40);
    read_rk("aes128_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk("aes128_rk11", 4'd11, 128'h0);
    read_rk("aes128_rk0", 4'd0, K128[255:128]);
    tick();

    $display("txn illegal key_len while done");
    bus.rk_idx = 4'd10;
    start_key(KJNK, 2'b11);
    chk_int("reject_err", int'(bus.err), 1);
    chk_int("reject_keys_valid", int'(bus.keys_valid), 1);
    chk_int("reject_nr", int'(bus.nr), 10);
    read_rk("reject_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    chk_int("reject_err_one_cycle", int'(bus.err), 0);

    $display("txn aes192 expand");
    start_key(K192, 2'b01);
    chk_int("aes192_nr_at_accept", int'(bus.nr), 12);
    chk("model_aes192_rk12", cand_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    wait_kv(n);
    chk_int("aes192_latency", n, 46);
    read_rk("aes192_rk12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
    read_rk("aes192_rk13", 4'd13, 128'h0);
    tick();

    $display("txn aes256 expand");
    start_key(K256, 2'b10);
    chk("model_aes256_rk14", cand_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    wait_kv(n);
    chk_int("aes256_latency", n, 52);
    read_rk("aes256_rk14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    read_rk("aes256_rk15", 4'd15, 128'h0);
    tick();

    $display("txn aes256 aborted by reset");
    start_key(K256, 2'b10);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_int("abort_ready", int'(bus.ready), 1);
    chk_int("abort_keys_valid", int'(bus.keys_valid), 0);
    chk_int("abort_nr", int'(bus.nr), 0);
    $display("txn aes128 after abort");
    start_key(K128, 2'b00);
    wait_kv(n);
    chk_int("restart_latency", n, 40);
    read_rk("restart_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();

    $display("txn aes192 with mid-expand start, then back-to-back aes128");
    start_key(K192, 2'b01);
    repeat (10) tick();
    bus.key     = KJNK;
    bus.key_len = 2'b11;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    chk_int("mid_start_no_err", int'(bus.err), 0);
    chk_int("mid_start_busy", int'(bus.ready), 0);
    wait_kv(n);
    chk_int("mid_start_latency", n + 11, 46);
    start_key(KNEW, 2'b00);
    chk_int("b2b_keys_valid_drop", int'(bus.keys_valid), 0);
    wait_kv(n);
    chk_int("b2b_latency", n, 40);
    read_rk("b2b_rk0", 4'd0, KNEW[255:128]);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
